mul_div_unit: RTL and testbench

Iterative 8-bit unsigned multiply/divide unit that sits directly upstream of the 8-bit load register in the processor datapath. It accepts one operation at a time, computes it over WIDTH clock cycles, and emits the result on `d_out` with a single-cycle `load` pulse. `load` and `d_out` wire straight to the register's `load` and `d_in`.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mul_div_unit.sv | 98 +++++++++
 tb/tb_mul_div_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: widths, op and
// state encodings, and small op-decode helpers.
package mdu_pkg;

  localparam int MDU_WIDTH = 8;
  localparam logic [MDU_WIDTH-1:0] DIV0_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    OP_MULLO = 2'b00,
    OP_MULHI = 2'b01,
    OP_DIVQ  = 2'b10,
    OP_DIVR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  // MULHI and DIVR both take their result from the upper accumulator half.
  function automatic logic op_sel_hi(input op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide: one shift/accumulate step per cycle,
// result strobed out with a single-cycle load pulse.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             load,
  output logic [WIDTH-1:0] d_out,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  op_e              op_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r, b_r;
  // hi is product upper half (plus carry) for MUL, partial remainder for DIV;
  // lo is the multiplier being shifted out for MUL, dividend/quotient for DIV.
  logic [WIDTH:0]   hi;
  logic [WIDTH-1:0] lo;

  logic [WIDTH:0]   mul_sum, div_shift, div_diff, hi_n;
  logic [WIDTH-1:0] lo_n, res;
  logic             div_ge;

  always_comb begin
    mul_sum   = hi + (lo[0] ? {1'b0, a_r} : '0);
    div_shift = {hi[WIDTH-1:0], lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_r};
    div_diff  = div_shift - {1'b0, b_r};
    if (op_is_div(op_r)) begin
      hi_n = div_ge ? div_diff : div_shift;
      lo_n = {lo[WIDTH-2:0], div_ge};
    end else begin
      hi_n = {1'b0, mul_sum[WIDTH:1]};
      lo_n = {mul_sum[0], lo[WIDTH-1:1]};
    end
    res = op_sel_hi(op_r) ? hi_n[WIDTH-1:0] : lo_n;
  end

  assign busy = (state != IDLE);
  assign load = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op_r        <= OP_MULLO;
      cnt         <= '0;
      a_r         <= '0;
      b_r         <= '0;
      hi          <= '0;
      lo          <= '0;
      d_out       <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          a_r  <= a;
          b_r  <= b;
          op_r <= op_e'(op);
          cnt  <= '0;
          hi   <= '0;
          lo   <= op[1] ? a : b;
          if (op[1] && b == '0) begin
            state       <= DONE;
            d_out       <= (op_e'(op) == OP_DIVQ) ? WIDTH'(DIV0_QUOTIENT) : a;
            div_by_zero <= 1'b1;
          end else begin
            state       <= CALC;
            div_by_zero <= 1'b0;
          end
        end
        CALC: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            d_out <= res;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, randomized ops
// against an arithmetic model, and hand-written busy/reset sequences.
module tb_mul_div_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op_i;
  logic [W-1:0] a_i, b_i;
  logic         busy, load, div_by_zero;
  logic [W-1:0] d_out;

  int checks = 0;
  int failures = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op_i), .a(a_i), .b(b_i),
    .busy(busy), .load(load), .d_out(d_out), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference for one operation.
  function automatic logic [W-1:0] model(input logic [1:0] op, input int a, input int b);
    int p;
    p = a * b;
    case (op)
      2'd0:    return W'(p % 256);
      2'd1:    return W'(p / 256);
      2'd2:    return (b == 0) ? 8'hFF : W'(a / b);
      default: return (b == 0) ? W'(a) : W'(a % b);
    endcase
  endfunction

  // Issue one op, find the load pulse (edge index relative to the accepting
  // edge), then confirm the strobe lasts one cycle and the result is held.
  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp,
                        input logic dz, input int lat);
    int seen;
    start = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    start = 1'b0;
    seen = -1;
    for (int e = 0; e <= W + 4; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      if (load === 1'b1) begin seen = e; break; end
    end
    chk({name, ".lat"}, seen, lat);
    chk({name, ".d_out"}, d_out, exp);
    chk({name, ".dz"}, div_by_zero, dz);
    @(posedge clk); #1;
    chk({name, ".load_off"}, {busy, load}, 2'b00);
    chk({name, ".hold"}, d_out, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nload, e1, e2;
    logic [W-1:0] d1, d2;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;

    vecs[0]  = '{2'd0, 8'd13,  8'd11, 8'h8F, 1'b0, W};
    vecs[1]  = '{2'd1, 8'hFF,  8'hFF, 8'hFE, 1'b0, W};
    vecs[2]  = '{2'd0, 8'hFF,  8'hFF, 8'h01, 1'b0, W};
    vecs[3]  = '{2'd2, 8'd200, 8'd7,  8'h1C, 1'b0, W};
    vecs[4]  = '{2'd3, 8'd200, 8'd7,  8'h04, 1'b0, W};
    vecs[5]  = '{2'd2, 8'h5A,  8'h00, 8'hFF, 1'b1, 0};
    vecs[6]  = '{2'd3, 8'h5A,  8'h00, 8'h5A, 1'b1, 0};
    vecs[7]  = '{2'd2, 8'd9,   8'd3,  8'h03, 1'b0, W};
    vecs[8]  = '{2'd2, 8'hFF,  8'h01, 8'hFF, 1'b0, W};
    vecs[9]  = '{2'd3, 8'd7,   8'd200, 8'h07, 1'b0, W};
    vecs[10] = '{2'd1, 8'h80,  8'h02, 8'h01, 1'b0, W};
    vecs[11] = '{2'd2, 8'h00,  8'h05, 8'h00, 1'b0, W};
    vecs[12] = '{2'd3, 8'hFF,  8'hFF, 8'h00, 1'b0, W};

    reset = 1'b1; start = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.outs", {busy, load, div_by_zero, d_out}, '0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset.idle", {busy, load}, 2'b00);

    for (int i = 0; i < 13; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].dz, vecs[i].lat);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 8'($urandom_range(0, 255));
      rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      run_op($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb),
             rop[1] && rb == 0, (rop[1] && rb == 0) ? 0 : W);
    end

    // start held high: one pulse per op, a/b changes mid-CALC only affect the next op
    nload = 0; e1 = -1; e2 = -1; d1 = '0; d2 = '0;
    start = 1'b1; op_i = 2'd0; a_i = 8'd3; b_i = 8'd5;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (e == 2) begin a_i = 8'd9; b_i = 8'd9; end
      if (e == 9) chk("hold_start.idle_gap", busy, 1'b0);
      if (e == 10) begin chk("hold_start.reaccept", busy, 1'b1); start = 1'b0; end
      if (load === 1'b1) begin
        nload++;
        if (nload == 1) begin e1 = e; d1 = d_out; end
        else begin e2 = e; d2 = d_out; end
      end
    end
    chk("hold_start.nload", nload, 2);
    chk("hold_start.e1", e1, W);
    chk("hold_start.d1", d1, 8'h0F);
    chk("hold_start.e2", e2, W + 10);
    chk("hold_start.d2", d2, 8'h51);

    // reset while counter==4 in CALC
    start = 1'b1; op_i = 2'd0; a_i = 8'd13; b_i = 8'd11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_calc.busy_before", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_calc.outs", {busy, load, div_by_zero, d_out}, '0);
    nload = 0;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk); #1;
      if (load === 1'b1 || busy === 1'b1) nload++;
    end
    chk("rst_calc.no_load", nload, 0);
    run_op("rst_calc.divq", 2'd2, 8'd9, 8'd3, 8'h03, 1'b0, W);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
